// File: rtl/cpu_control_fsm_if.sv
// Data-memory request handshake between the control sequencer and data memory.
// The sequencer is the master: it raises mem_req/mem_we and waits on mem_ready.
interface cpu_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: FETCH, DECODE, EXEC, optional MEM,
// plus a terminal HALT; also counts retired instructions.
module cpu_control_fsm #(
  parameter int RETIRE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           instr,
  input  logic                  flag_z,
  input  logic                  flag_n,
  cpu_control_fsm_if.master     mem_bus,
  output logic                  ir_load,
  output logic                  pc_enable,
  output logic                  pc_load,
  output logic                  reg_we,
  output logic                  alu_src_imm,
  output logic                  wb_sel,
  output logic                  halted,
  output logic [2:0]            state_out,
  output logic [RETIRE_W-1:0]   retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ALU_R  = 4'h0;
  localparam logic [3:0] OP_ALU_I  = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_JUMP   = 4'h5;
  localparam logic [3:0] OP_HALT   = 4'hF;

  state_t                state;
  state_t                next_state;
  logic [7:0]            ir_q;
  logic                  flag_z_q;
  logic                  flag_n_q;
  logic [RETIRE_W-1:0]   retired_q;

  logic [3:0]            opcode;
  logic [3:0]            cond;
  logic                  is_alu_r;
  logic                  is_alu_i;
  logic                  is_load;
  logic                  is_store;
  logic                  is_branch;
  logic                  is_jump;
  logic                  is_halt;
  logic                  branch_taken;
  logic                  mem_req_c;
  logic                  mem_we_c;

  // Only the opcode and branch condition fields steer the sequencer.
  logic                  unused_instr_low;
  assign unused_instr_low = ^instr[7:0];

  assign opcode    = ir_q[7:4];
  assign cond      = ir_q[3:0];
  assign is_alu_r  = (opcode == OP_ALU_R);
  assign is_alu_i  = (opcode == OP_ALU_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JUMP);
  assign is_halt   = (opcode == OP_HALT);

  // Branch decisions use the flags frozen at the end of DECODE, never the live ALU flags.
  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      4'h0:    branch_taken = 1'b1;
      4'h1:    branch_taken = flag_z_q;
      4'h2:    branch_taken = !flag_z_q;
      4'h3:    branch_taken = flag_n_q;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir_q      <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= next_state;
      if (ir_load) begin
        ir_q <= instr[15:8];
      end
      if (state == S_DECODE) begin
        flag_z_q <= flag_z;
        flag_n_q <= flag_n;
      end
      if (pc_enable || pc_load) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    next_state  = state;
    ir_load     = 1'b0;
    pc_enable   = 1'b0;
    pc_load     = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = S_EXEC;
      end
      S_EXEC: begin
        next_state = S_FETCH;
        if (is_alu_r) begin
          reg_we    = 1'b1;
          pc_enable = 1'b1;
        end else if (is_alu_i) begin
          reg_we      = 1'b1;
          alu_src_imm = 1'b1;
          pc_enable   = 1'b1;
        end else if (is_jump || (is_branch && branch_taken)) begin
          pc_load = 1'b1;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else if (is_halt) begin
          next_state = S_HALT;
        end else begin
          pc_enable = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = is_store;
        alu_src_imm = 1'b1;
        if (mem_bus.mem_ready) begin
          pc_enable  = 1'b1;
          next_state = S_FETCH;
          if (is_load) begin
            reg_we = 1'b1;
            wb_sel = 1'b1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  assign mem_bus.mem_req = mem_req_c;
  assign mem_bus.mem_we  = mem_we_c;
  assign state_out       = state;
  assign retired_count   = retired_q;

  // Structural invariants of the strobe decode.
  assert property (@(posedge clk) disable iff (reset) !(pc_enable && pc_load));
  assert property (@(posedge clk) disable iff (reset) !(mem_we_c && !mem_req_c));
  assert property (@(posedge clk) disable iff (reset)
                   !(reg_we && (state != S_EXEC) && (state != S_MEM)));

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Table-driven, scoreboarded bench for cpu_control_fsm: one vector per clock cycle,
// expected state/strobes/retire count queued on drive and compared mid-cycle.
module tb_cpu_control_fsm;

  localparam int RW = 4;
  localparam logic [15:0] JUNK = 16'h5A5A;

  // Strobe bundle order: ir_load pc_enable pc_load reg_we alu_src_imm wb_sel mem_req mem_we halted
  localparam logic [8:0] O_NONE    = 9'b000000000;
  localparam logic [8:0] O_FETCH   = 9'b100000000;
  localparam logic [8:0] O_ALUR    = 9'b010100000;
  localparam logic [8:0] O_ALUI    = 9'b010110000;
  localparam logic [8:0] O_PCLD    = 9'b001000000;
  localparam logic [8:0] O_PCEN    = 9'b010000000;
  localparam logic [8:0] O_LD_WAIT = 9'b000010100;
  localparam logic [8:0] O_LD_DONE = 9'b010111100;
  localparam logic [8:0] O_ST_WAIT = 9'b000010110;
  localparam logic [8:0] O_ST_DONE = 9'b010010110;
  localparam logic [8:0] O_HALT    = 9'b000000001;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   instr;
  logic          flag_z;
  logic          flag_n;
  logic          ir_load;
  logic          pc_enable;
  logic          pc_load;
  logic          reg_we;
  logic          alu_src_imm;
  logic          wb_sel;
  logic          halted;
  logic [2:0]    state_out;
  logic [RW-1:0] retired_count;

  cpu_control_fsm_if bus();

  cpu_control_fsm #(.RETIRE_W(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .mem_bus       (bus.master),
    .ir_load       (ir_load),
    .pc_enable     (pc_enable),
    .pc_load       (pc_load),
    .reg_we        (reg_we),
    .alu_src_imm   (alu_src_imm),
    .wb_sel        (wb_sel),
    .halted        (halted),
    .state_out     (state_out),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] ins;
    logic        z;
    logic        n;
    logic        rdy;
    logic [2:0]  st;
    logic [8:0]  outs;
    string       tag;
  } vec_t;

  typedef struct {
    logic [2:0]    st;
    logic [8:0]    outs;
    logic [RW-1:0] cnt;
    string         tag;
  } exp_t;

  vec_t          tbl[$];
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [RW-1:0] model_cnt = '0;

  function automatic vec_t mkv(input logic rst, input logic [15:0] ins, input logic z,
                               input logic n, input logic rdy, input logic [2:0] st,
                               input logic [8:0] outs, input string tag);
    vec_t v;
    v.rst = rst; v.ins = ins; v.z = z; v.n = n; v.rdy = rdy;
    v.st = st; v.outs = outs; v.tag = tag;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  // FETCH/DECODE/EXEC triple; flags are inverted in EXEC to prove they are ignored there.
  task automatic addInstr(input logic [15:0] ins, input logic zd, input logic nd,
                          input logic [8:0] exec_outs, input string tag);
    add(mkv(1'b0, ins,  1'b0, 1'b0, 1'b1, 3'd0, O_FETCH, tag));
    add(mkv(1'b0, JUNK, zd,   nd,   1'b1, 3'd1, O_NONE,  tag));
    add(mkv(1'b0, JUNK, !zd,  !nd,  1'b1, 3'd2, exec_outs, tag));
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset         = v.rst;
    instr         = v.ins;
    flag_z        = v.z;
    flag_n        = v.n;
    bus.mem_ready = v.rdy;
    e.st   = v.st;
    e.outs = v.outs;
    e.cnt  = model_cnt;
    e.tag  = v.tag;
    sb.push_back(e);
    vectors++;
    if (v.rst) model_cnt = '0;
    else if (v.outs[7] || v.outs[6]) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [8:0] got;
    @(negedge clk);
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard empty at vector %0d", vectors);
    end else begin
      e = sb.pop_front();
      got = {ir_load, pc_enable, pc_load, reg_we, alu_src_imm, wb_sel,
             bus.mem_req, bus.mem_we, halted};
      if (state_out !== e.st) begin
        miscompares++;
        $display("[TB] FAIL %s state_out vec %0d got %0d want %0d", e.tag, vectors, state_out, e.st);
      end
      if (got !== e.outs) begin
        miscompares++;
        $display("[TB] FAIL %s strobes vec %0d got %b want %b", e.tag, vectors, got, e.outs);
      end
      if (retired_count !== e.cnt) begin
        miscompares++;
        $display("[TB] FAIL %s retired_count vec %0d got %0d want %0d", e.tag, vectors, retired_count, e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; instr = '0; flag_z = 1'b0; flag_n = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    add(mkv(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH, "reset"));
    for (int i = 0; i < 4; i++) begin
      add(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH, "alu_r_held"));
      add(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd1, O_NONE,  "alu_r_held"));
      add(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, O_ALUR,  "alu_r_held"));
    end
    addInstr(16'h1234, 1'b0, 1'b0, O_ALUI, "alu_imm");
    addInstr(16'h4100, 1'b1, 1'b0, O_PCLD, "br_z_taken");
    addInstr(16'h4100, 1'b0, 1'b0, O_PCEN, "br_z_not");
    addInstr(16'h4200, 1'b0, 1'b0, O_PCLD, "br_nz_taken");
    addInstr(16'h4200, 1'b1, 1'b0, O_PCEN, "br_nz_not");
    addInstr(16'h4300, 1'b0, 1'b1, O_PCLD, "br_n_taken");
    addInstr(16'h4300, 1'b1, 1'b0, O_PCEN, "br_n_not");
    addInstr(16'h4000, 1'b0, 1'b0, O_PCLD, "br_always");
    addInstr(16'h4700, 1'b1, 1'b1, O_PCEN, "br_never");
    addInstr(16'h5ABC, 1'b0, 1'b0, O_PCLD, "jump");
    addInstr(16'h6000, 1'b0, 1'b0, O_PCEN, "nop_6");
    addInstr(16'hE123, 1'b0, 1'b0, O_PCEN, "nop_e");

    addInstr(16'h2000, 1'b0, 1'b0, O_NONE, "load_w3");
    for (int i = 0; i < 3; i++)
      add(mkv(1'b0, JUNK, 1'b0, 1'b0, 1'b0, 3'd3, O_LD_WAIT, "load_w3"));
    add(mkv(1'b0, JUNK, 1'b0, 1'b0, 1'b1, 3'd3, O_LD_DONE, "load_w3"));

    addInstr(16'h3000, 1'b0, 1'b0, O_NONE, "store_w0");
    add(mkv(1'b0, JUNK, 1'b0, 1'b0, 1'b1, 3'd3, O_ST_DONE, "store_w0"));

    addInstr(16'h3456, 1'b0, 1'b0, O_NONE, "store_w1");
    add(mkv(1'b0, JUNK, 1'b0, 1'b0, 1'b0, 3'd3, O_ST_WAIT, "store_w1"));
    add(mkv(1'b0, JUNK, 1'b0, 1'b0, 1'b1, 3'd3, O_ST_DONE, "store_w1"));

    add(mkv(1'b1, 16'h6000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH, "wrap_reset"));
    for (int i = 0; i < 16; i++)
      addInstr(16'h6000, 1'b0, 1'b0, O_PCEN, "nop_wrap");

    for (int i = 0; i < tbl.size(); i++)
      runCycle(tbl[i]);

    // Reset while a load is stalled in MEM: request must drop as the state returns to FETCH.
    runCycle(mkv(1'b0, 16'h2000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH,   "rst_mid_mem"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b0, 3'd1, O_NONE,    "rst_mid_mem"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b0, 3'd2, O_NONE,    "rst_mid_mem"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b0, 3'd3, O_LD_WAIT, "rst_mid_mem"));
    runCycle(mkv(1'b1, JUNK,     1'b0, 1'b0, 1'b0, 3'd3, O_LD_WAIT, "rst_mid_mem"));
    runCycle(mkv(1'b0, 16'h6000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH,   "rst_mid_mem"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b0, 3'd1, O_NONE,    "rst_mid_mem"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b0, 3'd2, O_PCEN,    "rst_mid_mem"));

    // HALT is sticky against any input until reset, and retires nothing.
    runCycle(mkv(1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 3'd0, O_FETCH, "halt"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b1, 3'd1, O_NONE,  "halt"));
    runCycle(mkv(1'b0, JUNK,     1'b0, 1'b0, 1'b1, 3'd2, O_NONE,  "halt"));
    for (int i = 0; i < 50; i++)
      runCycle(mkv(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 3'd4, O_HALT, "halt_hold"));
    runCycle(mkv(1'b1, JUNK,     1'b0, 1'b0, 1'b0, 3'd4, O_HALT,  "halt_reset"));
    runCycle(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, O_FETCH, "halt_reset"));

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 16-bit CPU. It drives the program counter's increment enable and branch load, the instruction register load, the register-file write and writeback select, and the data-memory request handshake. It decodes the opcode field of the fetched instruction and sequences each instruction through fetch, decode, execute and an optional memory phase. It sits between instruction memory / IR and the datapath, and is the only source of `pc_enable`.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `instr`  in  16  instruction word from instruction memory; valid during FETCH and captured by the IR.
- `flag_z`  in  1  ALU zero flag; sampled in DECODE.
- `flag_n`  in  1  ALU negative flag; sampled in DECODE.
- `mem_ready`  in  1  data memory accepts or completes the current request.
- `ir_load`  out  1  IR captures `instr` at the end of this cycle.
- `pc_enable`  out  1  PC increments by 1 at the end of this cycle.
- `pc_load`  out  1  PC loads the branch/jump target at the end of this cycle.
- `reg_we`  out  1  register-file write strobe.
- `alu_src_imm`  out  1  ALU operand B is the immediate (1) or a register (0).
- `wb_sel`  out  1  writeback source is memory (1) or ALU (0).
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  data-memory write; only ever asserted together with `mem_req`.
- `halted`  out  1  core is stopped.
- `state_out`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
- `retired_count`  out  RETIRE_W  number of completed instructions.

## Operation
- **Opcode field.** The opcode is IR[15:12]:
  - 0000: ALU register op.
  - 0001: ALU immediate op.
  - 0010: LOAD.
  - 0011: STORE.
  - 0100: BRANCH.
  - 0101: JUMP.
  - 1111: HALT.
  - All other codes: NOP.
- **Branch condition.** The condition is IR[11:8]:
  - 0000: always taken.
  - 0001: taken if Z.
  - 0010: taken if !Z.
  - 0011: taken if N.
  - Any other code: never taken.
- **Flag capture.** Flags are registered in DECODE. Execute uses the registered copies.
- **Output decode.** Outputs are decoded from the state register and the registered IR opcode. Every output not listed as asserted in a state is 0.
- **FETCH.** `ir_load`=1. Next state is DECODE.
- **DECODE.** All strobes are 0; flags are captured. Next state is EXEC.
- **EXEC**, by opcode:
  - ALU register op: `reg_we`=1, `alu_src_imm`=0, `pc_enable`=1. Next state is FETCH.
  - ALU immediate op: `reg_we`=1, `alu_src_imm`=1, `pc_enable`=1. Next state is FETCH.
  - BRANCH taken, or JUMP: `pc_load`=1 and `pc_enable`=0. Next state is FETCH.
  - BRANCH not taken: `pc_enable`=1. Next state is FETCH.
  - NOP: `pc_enable`=1. Next state is FETCH.
  - LOAD or STORE: no strobes. Next state is MEM.
  - HALT: no strobes, and the PC does not advance. Next state is HALT.
- **MEM.** `mem_req`=1, with `mem_we`=1 for STORE. `alu_src_imm`=1 (address = base + immediate).
  - The state holds while `mem_ready`=0.
  - In the cycle where `mem_ready`=1:
    - `pc_enable`=1.
    - For LOAD, also `reg_we`=1 and `wb_sel`=1.
    - Next state is FETCH.
- **HALT.** `halted`=1 and all strobes are 0. The state is held until `reset`.
- **Retirement.** `retired_count` increments by 1 in every cycle where `pc_enable` or `pc_load` is 1. The two are mutually exclusive, so there is never a double increment. The counter wraps from 2^RETIRE_W−1 to 0. HALT is not counted.
- **Exclusivity invariants:**
  - `pc_enable` and `pc_load` are never 1 together.
  - `mem_we` is never 1 without `mem_req`.
  - `reg_we` is never 1 outside EXEC or MEM.

## Timing
- **Reset values**, applied on the first rising edge with `reset`=1:
  - state = FETCH, registered IR = 0, registered flags = 0, `retired_count` = 0.
  - Outputs during reset cycles: `state_out`=0 and `ir_load`=1 (FETCH decode); all other outputs 0.
- **Reset from any state**, including MEM with a pending request or HALT: the block is in FETCH on the next edge. `mem_req` drops in the same cycle the state changes.
- **Latency per instruction:**
  - ALU, branch, jump, NOP: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD/STORE: 4 + W cycles, where W is the number of MEM cycles with `mem_ready`=0.
- **`mem_ready` handling:** sampled only in MEM; ignored in every other state. If `mem_ready` is 1 on the first MEM cycle, the instruction completes in that cycle.
- **Flag timing:** a flag change after the DECODE edge does not affect the branch decision.

## Test plan
- Reset, then instr=0x0000 held: IR captures 0x0000 (ALU register op), so only the ALU register-op path is exercised.
  - `state_out` sequence is 0,1,2,0,1,2…
  - `pc_enable` and `reg_we` are 1 every 3rd cycle.
  - `retired_count`=4 after 12 cycles.
- BRANCH instr=0x4100 (condition Z): Z=1 at DECODE gives `pc_load`=1 and `pc_enable`=0 in EXEC; Z=0 gives `pc_enable`=1. Toggling Z during EXEC changes nothing.
- LOAD instr=0x2000 with `mem_ready` low for 3 cycles: MEM lasts 4 cycles with `mem_req`=1 and `mem_we`=0; the final cycle has `reg_we`=`wb_sel`=`pc_enable`=1. Total is 7 cycles.
- STORE instr=0x3000 with `mem_ready`=1 immediately: 4 cycles; `mem_we`=1 only in the single MEM cycle; `reg_we`=0 throughout.
- HALT instr=0xF000: `halted`=1 and `state_out`=4 persist for 50 cycles, with no `pc_enable`/`pc_load` and no count change. Then `reset` is pulsed: FETCH with `retired_count`=0.
- RETIRE_W=4, NOPs (instr=0x6000): after 16 retirements the counter reads 0. Asserting `reset` mid-MEM drops `mem_req` the next cycle and returns `state_out` to 0.
